// File: rtl/dmem_responder.sv
// Data memory with combinational read port and a valid/ready dump streamer.
// Optional DMEM_DUMP_SKIP_ZERO_EN: zero words produce no dump beat.
module dmem_responder #(
  parameter int N     = 64,
  parameter int DEPTH = 64
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  output logic [N-1:0] DM_readData,
  input  logic         dump,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_busy,
  output logic         dump_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VALID,
    DONE
  } state_e;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          unused_addr;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          dump_q;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  data_q, data_d;
  logic          start;
  logic          last;

  assign idx         = DM_addr[AW+2:3];
  assign unused_addr = ^{DM_addr[N-1:AW+3], DM_addr[2:0]};
  assign DM_readData = mem_q[idx];

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (DM_writeEnable) begin
      mem_q[idx] <= DM_writeData;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dump_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dump_q  <= dump;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign start = dump && !dump_q;
  assign last  = (ptr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
`ifdef DMEM_DUMP_SKIP_ZERO_EN
        if (mem_q[ptr_q] == '0) begin
          if (last) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end else begin
          data_d  = mem_q[ptr_q];
          addr_d  = {{(N-AW-3){1'b0}}, ptr_q, 3'b000};
          state_d = VALID;
        end
`else
        data_d  = mem_q[ptr_q];
        addr_d  = {{(N-AW-3){1'b0}}, ptr_q, 3'b000};
        state_d = VALID;
`endif
      end
      VALID: begin
        if (dump_ready) begin
          if (last) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        ptr_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_valid = (state_q == VALID);
  assign dump_busy  = (state_q != IDLE);
  assign dump_done  = (state_q == DONE);
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: reads, dumps, backpressure,
// writes during a dump, reset mid-dump and ignored restart edges.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [63:0] DM_addr;
  logic [63:0] DM_writeData;
  logic        DM_writeEnable;
  logic [63:0] DM_readData;
  logic        dump;
  logic        dump_valid;
  logic        dump_ready;
  logic [63:0] dump_addr;
  logic [63:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int cyc    = 0;
  int last_cyc = 0;
  bit gap_chk = 0;
  logic [127:0] exp_q[$];

  dmem_responder #(.N(64), .DEPTH(64)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .DM_addr       (DM_addr),
    .DM_writeData  (DM_writeData),
    .DM_writeEnable(DM_writeEnable),
    .DM_readData   (DM_readData),
    .dump          (dump),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_addr     (dump_addr),
    .dump_data     (dump_data),
    .dump_busy     (dump_busy),
    .dump_done     (dump_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor: every accepted beat is popped and compared.
  initial forever begin
    logic [127:0] e;
    @(negedge clk);
    if (reset && dump_valid && dump_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_extra addr=%0h data=%0h required=none",
                 dump_addr, dump_data);
      end else begin
        e = exp_q.pop_front();
        if ({dump_addr, dump_data} !== e) begin
          errors++;
          $display("FAIL beat addr=%0h data=%0h required addr=%0h data=%0h",
                   dump_addr, dump_data, e[127:64], e[63:0]);
        end
      end
      if (gap_chk && beats > 0) begin
        checks++;
        if (cyc - last_cyc != 2) begin
          errors++;
          $display("FAIL beat_gap got=%0d required=2", cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      beats++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input logic [63:0] d);
    DM_addr        = 64'(i) * 64'd8;
    DM_writeData   = d;
    DM_writeEnable = 1;
    step();
    DM_writeEnable = 0;
  endtask

  task automatic start_dump();
    dump = 1;
    step();
    dump = 0;
  endtask

  task automatic wait_done(input int budget, output int nd);
    nd = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dump_done) nd++;
      if (nd > 0 && !dump_done && !dump_busy) break;
    end
    step();
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 400; i++) begin
      if (beats >= n) break;
      step();
    end
  endtask

  task automatic test_reset();
    step();
    step();
    @(negedge clk);
    DM_addr = 0;
    #1;
    checks++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b required=000",
               {dump_valid, dump_busy, dump_done});
    end
    checks++;
    if (dump_addr !== 0 || dump_data !== 0) begin
      errors++;
      $display("FAIL reset_dump got=%0h/%0h required=0/0",
               dump_addr, dump_data);
    end
    checks++;
    if (DM_readData !== 0) begin
      errors++;
      $display("FAIL reset_mem got=%0h required=0", DM_readData);
    end
    step();
    reset = 1;
    step();
  endtask

  task automatic test_write_read();
    wr(2, 64'hDEAD_BEEF_0000_0001);
    DM_addr = 16;
    #1;
    checks++;
    if (DM_readData !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL rd16 got=%0h required=deadbeef00000001", DM_readData);
    end
    DM_addr = 19;
    #1;
    checks++;
    if (DM_readData !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL rd19 got=%0h required=deadbeef00000001", DM_readData);
    end
    DM_addr = 0;
    #1;
    checks++;
    if (DM_readData !== 0) begin
      errors++;
      $display("FAIL rd0 got=%0h required=0", DM_readData);
    end
    step();
  endtask

  task automatic test_full_dump();
    int nd;
    for (int i = 0; i < 64; i++) wr(i, 64'(i + 100));
    for (int i = 0; i < 64; i++)
      exp_q.push_back({64'(i * 8), 64'(i + 100)});
    beats = 0;
    gap_chk = 1;
    dump_ready = 1;
    dump = 1;
    @(negedge clk);
    checks++;
    if (dump_busy !== 0) begin
      errors++;
      $display("FAIL lat_busy0 got=%b required=0", dump_busy);
    end
    step();
    dump = 0;
    @(negedge clk);
    checks++;
    if (dump_busy !== 1 || dump_valid !== 0) begin
      errors++;
      $display("FAIL lat_load got=%b%b required=10", dump_busy, dump_valid);
    end
    @(negedge clk);
    checks++;
    if (dump_valid !== 1) begin
      errors++;
      $display("FAIL lat_valid got=%b required=1", dump_valid);
    end
    wait_done(200, nd);
    gap_chk = 0;
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL full_done got=%0d required=1", nd);
    end
    checks++;
    if (beats !== 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_beats got=%0d left=%0d required=64/0",
               beats, exp_q.size());
    end
    checks++;
    if (dump_busy !== 0) begin
      errors++;
      $display("FAIL full_busy got=%b required=0", dump_busy);
    end
  endtask

  task automatic test_backpressure();
    int nd;
    for (int i = 0; i < 64; i++)
      exp_q.push_back({64'(i * 8), 64'(i + 100)});
    beats = 0;
    dump_ready = 1;
    start_dump();
    wait_beats(3);
    dump_ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dump_valid) break;
    end
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (dump_valid !== 1 || dump_addr !== 24 || dump_data !== 103) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got=%b/%0d/%0d required=1/24/103",
                 i, dump_valid, dump_addr, dump_data);
      end
    end
    step();
    dump_ready = 1;
    wait_done(220, nd);
    checks++;
    if (nd !== 1 || beats !== 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_total got=%0d/%0d/%0d required=1/64/0",
               nd, beats, exp_q.size());
    end
  endtask

  task automatic test_write_during_dump();
    int nd;
    logic [63:0] v;
    for (int i = 0; i < 64; i++) begin
      v = 64'(i + 100);
      if (i == 40) v = 64'h55;
      exp_q.push_back({64'(i * 8), v});
    end
    beats = 0;
    dump_ready = 1;
    start_dump();
    wait_beats(6);
    wr(2, 64'd1);
    wr(40, 64'h55);
    wait_done(200, nd);
    checks++;
    if (nd !== 1 || beats !== 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wdd_total got=%0d/%0d/%0d required=1/64/0",
               nd, beats, exp_q.size());
    end
    DM_addr = 16;
    #1;
    checks++;
    if (DM_readData !== 1) begin
      errors++;
      $display("FAIL wdd_mem got=%0h required=1", DM_readData);
    end
  endtask

  task automatic test_reset_mid_dump();
    int nd;
    int nexp;
    for (int i = 0; i < 64; i++) begin
      logic [63:0] v;
      v = 64'(i + 100);
      if (i == 2) v = 64'd1;
      if (i == 40) v = 64'h55;
      exp_q.push_back({64'(i * 8), v});
    end
    beats = 0;
    dump_ready = 1;
    DM_addr = 40;
    start_dump();
    wait_beats(10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dump_valid) break;
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
      errors++;
      $display("FAIL rmd_flags got=%b required=000",
               {dump_valid, dump_busy, dump_done});
    end
    checks++;
    if (dump_addr !== 0 || dump_data !== 0 || DM_readData !== 0) begin
      errors++;
      $display("FAIL rmd_vals got=%0h/%0h/%0h required=0/0/0",
               dump_addr, dump_data, DM_readData);
    end
    exp_q.delete();
    step();
    reset = 1;
    step();
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    nexp = 0;
`else
    nexp = 64;
    for (int i = 0; i < 64; i++) exp_q.push_back({64'(i * 8), 64'd0});
`endif
    beats = 0;
    start_dump();
    wait_done(200, nd);
    checks++;
    if (nd !== 1 || beats !== nexp || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rmd_redump got=%0d/%0d/%0d required=1/%0d/0",
               nd, beats, exp_q.size(), nexp);
    end
  endtask

  task automatic test_skip_and_busy_edge();
    int nd;
    int nexp;
    bit seen_busy;
    wr(3, 64'hA3);
    wr(63, 64'h0123_4567);
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    nexp = 2;
    exp_q.push_back({64'd24, 64'hA3});
    exp_q.push_back({64'd504, 64'h0123_4567});
`else
    nexp = 64;
    for (int i = 0; i < 64; i++) begin
      logic [63:0] v;
      v = 0;
      if (i == 3) v = 64'hA3;
      if (i == 63) v = 64'h0123_4567;
      exp_q.push_back({64'(i * 8), v});
    end
`endif
    beats = 0;
    dump_ready = 1;
    start_dump();
    step();
    step();
    start_dump();
    wait_done(200, nd);
    checks++;
    if (nd !== 1 || beats !== nexp || exp_q.size() != 0) begin
      errors++;
      $display("FAIL skip_total got=%0d/%0d/%0d required=1/%0d/0",
               nd, beats, exp_q.size(), nexp);
    end
    seen_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dump_busy) seen_busy = 1;
    end
    checks++;
    if (seen_busy !== 0) begin
      errors++;
      $display("FAIL busy_edge_queued got=1 required=0");
    end
  endtask

  initial begin
    reset = 0;
    DM_addr = 0;
    DM_writeData = 0;
    DM_writeEnable = 0;
    dump = 0;
    dump_ready = 0;
    test_reset();
    test_write_read();
    test_full_dump();
    test_backpressure();
    test_write_during_dump();
    test_reset_mid_dump();
    test_skip_and_busy_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
